// File: rtl/alarm_ctrl.sv
// Alarm sequencer: IDLE/ARMED/RINGING/SNOOZE driven by the 1 Hz tick strobe,
// with a 1 Hz beeping buzzer, snooze/stop buttons and a ring timeout.
module alarm_ctrl #(
   parameter int SNOOZE_S       = 300,
   parameter int RING_TIMEOUT_S = 60
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tick_1hz,
   input  logic [4:0] cur_hh,
   input  logic [5:0] cur_mm,
   input  logic [4:0] alm_hh,
   input  logic [5:0] alm_mm,
   input  logic       alarm_en,
   input  logic       btn_snooze,
   input  logic       btn_stop,
   output logic       buzzer,
   output logic       ringing,
   output logic       snoozing,
   output logic [1:0] state
);

   localparam int RING_W = $clog2(RING_TIMEOUT_S + 1);
   localparam int SNZ_W  = $clog2(SNOOZE_S + 1);
   localparam logic [RING_W-1:0] RING_LAST = RING_W'(RING_TIMEOUT_S - 1);
   localparam logic [SNZ_W-1:0]  SNZ_LAST  = SNZ_W'(SNOOZE_S - 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ARMED   = 2'd1,
      RINGING = 2'd2,
      SNOOZE  = 2'd3
   } state_t;

   state_t              state_q, state_d;
   logic [RING_W-1:0]   ring_cnt_q, ring_cnt_d;
   logic [SNZ_W-1:0]    snz_cnt_q, snz_cnt_d;
   logic                beep_ph_q, beep_ph_d;
   logic                match_q;
   logic                match;
   logic                fire;

   assign match = (cur_hh == alm_hh) && (cur_mm == alm_mm);
   // Rising edge only, so a whole matching minute fires at most once.
   assign fire  = match && !match_q;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         ring_cnt_q <= '0;
         snz_cnt_q  <= '0;
         beep_ph_q  <= 1'b0;
         match_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         ring_cnt_q <= ring_cnt_d;
         snz_cnt_q  <= snz_cnt_d;
         beep_ph_q  <= beep_ph_d;
         match_q    <= match;
      end
   end

   // NOTE: every output of this block is defaulted first so no path can
   // leave a signal unassigned and infer a latch.
   always_comb begin
      state_d    = state_q;
      ring_cnt_d = ring_cnt_q;
      snz_cnt_d  = snz_cnt_q;
      beep_ph_d  = beep_ph_q;
      unique case (state_q)
         IDLE: begin
            if (alarm_en) state_d = ARMED;
         end
         ARMED: begin
            if (!alarm_en) begin
               state_d = IDLE;
            end else if (fire) begin
               state_d    = RINGING;
               ring_cnt_d = '0;
               beep_ph_d  = 1'b1;
            end
         end
         RINGING: begin
            if (!alarm_en) begin
               state_d = IDLE;
            end else if (btn_stop) begin
               state_d = ARMED;
            end else if (btn_snooze) begin
               state_d   = SNOOZE;
               snz_cnt_d = '0;
            end else if (tick_1hz) begin
               if (ring_cnt_q == RING_LAST) begin
                  state_d = ARMED;
               end else begin
                  ring_cnt_d = ring_cnt_q + RING_W'(1);
                  beep_ph_d  = !beep_ph_q;
               end
            end
         end
         SNOOZE: begin
            if (!alarm_en) begin
               state_d = IDLE;
            end else if (btn_stop) begin
               state_d = ARMED;
            end else if (tick_1hz) begin
               if (snz_cnt_q == SNZ_LAST) begin
                  state_d    = RINGING;
                  ring_cnt_d = '0;
                  beep_ph_d  = 1'b1;
               end else begin
                  snz_cnt_d = snz_cnt_q + SNZ_W'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Decoded straight from registers so async reset silences the buzzer at once.
   assign buzzer   = (state_q == RINGING) && beep_ph_q;
   assign ringing  = (state_q == RINGING);
   assign snoozing = (state_q == SNOOZE);
   assign state    = state_q;

endmodule

// File: tb/tb_alarm_ctrl.sv
// Directed self-checking bench for alarm_ctrl (SNOOZE_S=3, RING_TIMEOUT_S=4,
// tick every 10 cycles).
module tb_alarm_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       tick_1hz = 1'b0;
   logic [4:0] cur_hh = 5'd7;
   logic [5:0] cur_mm = 6'd29;
   logic [4:0] alm_hh = 5'd7;
   logic [5:0] alm_mm = 6'd30;
   logic       alarm_en = 1'b0;
   logic       btn_snooze = 1'b0;
   logic       btn_stop = 1'b0;
   logic       buzzer, ringing, snoozing;
   logic [1:0] state;

   int n_tests = 0;
   int n_fail  = 0;

   localparam logic [1:0] S_IDLE = 2'd0, S_ARMED = 2'd1, S_RING = 2'd2, S_SNZ = 2'd3;

   alarm_ctrl #(.SNOOZE_S(3), .RING_TIMEOUT_S(4)) dut (
      .clk(clk), .rst(rst), .tick_1hz(tick_1hz),
      .cur_hh(cur_hh), .cur_mm(cur_mm), .alm_hh(alm_hh), .alm_mm(alm_mm),
      .alarm_en(alarm_en), .btn_snooze(btn_snooze), .btn_stop(btn_stop),
      .buzzer(buzzer), .ringing(ringing), .snoozing(snoozing), .state(state)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // One clock: inputs already set, advance past the edge and settle.
   task automatic cycle();
      @(posedge clk);
      #1;
      tick_1hz   = 1'b0;
      btn_snooze = 1'b0;
      btn_stop   = 1'b0;
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   // 9 quiet cycles then one tick cycle.
   task automatic one_tick();
      idle_cycles(9);
      tick_1hz = 1'b1;
      cycle();
   endtask

   task automatic check_st(input string tag, input logic [1:0] st, input logic bz);
      check({tag, "_state"}, state, st);
      check({tag, "_buzzer"}, buzzer, bz);
      check({tag, "_ringing"}, ringing, st == S_RING);
      check({tag, "_snoozing"}, snoozing, st == S_SNZ);
   endtask

   // cur 07:29 -> 07:30 produces a fresh match edge.
   task automatic match_edge();
      cur_mm = 6'd29;
      cycle();
      cur_mm = 6'd30;
      cycle();
   endtask

   initial begin
      #12;
      check_st("reset", S_IDLE, 1'b0);
      rst = 1'b0;
      alarm_en = 1'b1;
      cycle();
      check_st("arm", S_ARMED, 1'b0);

      // 1: ring, beep pattern, timeout back to ARMED
      cur_mm = 6'd30;
      cycle();
      check_st("fire", S_RING, 1'b1);
      one_tick();
      check_st("t1_tick1", S_RING, 1'b0);
      one_tick();
      check_st("t1_tick2", S_RING, 1'b1);
      one_tick();
      check_st("t1_tick3", S_RING, 1'b0);
      one_tick();
      check_st("t1_timeout", S_ARMED, 1'b0);
      one_tick();
      check_st("t1_no_refire", S_ARMED, 1'b0);

      // 2: snooze then re-ring after 3 ticks
      match_edge();
      check_st("t2_ring", S_RING, 1'b1);
      btn_snooze = 1'b1;
      cycle();
      check_st("t2_snooze", S_SNZ, 1'b0);
      btn_snooze = 1'b1;
      cycle();
      check_st("t2_snz_ignored", S_SNZ, 1'b0);
      one_tick();
      one_tick();
      check_st("t2_tick2", S_SNZ, 1'b0);
      one_tick();
      check_st("t2_rering", S_RING, 1'b1);

      // 3: stop beats snooze; stop from snooze; no re-fire while held
      btn_stop = 1'b1;
      btn_snooze = 1'b1;
      cycle();
      check_st("t3_stop_wins", S_ARMED, 1'b0);
      one_tick();
      one_tick();
      check_st("t3_held_match", S_ARMED, 1'b0);
      match_edge();
      check_st("t3_ring", S_RING, 1'b1);
      btn_snooze = 1'b1;
      cycle();
      btn_stop = 1'b1;
      cycle();
      check_st("t3_stop_snz", S_ARMED, 1'b0);
      match_edge();
      alarm_en = 1'b0;
      btn_stop = 1'b1;
      cycle();
      check_st("t3_en_beats_stop", S_IDLE, 1'b0);

      // 4: enable inside matching minute does not fire; disable during snooze
      cur_mm = 6'd29;
      cycle();
      cur_mm = 6'd30;
      cycle();
      alarm_en = 1'b1;
      cycle();
      check_st("t4_en_in_match", S_ARMED, 1'b0);
      idle_cycles(5);
      check_st("t4_no_ring", S_ARMED, 1'b0);
      match_edge();
      btn_snooze = 1'b1;
      cycle();
      check_st("t4_snooze", S_SNZ, 1'b0);
      alarm_en = 1'b0;
      cycle();
      check_st("t4_disable", S_IDLE, 1'b0);

      // 5: async reset mid-ring, re-arm without ringing
      alarm_en = 1'b1;
      cycle();
      match_edge();
      check_st("t5_ring", S_RING, 1'b1);
      #2 rst = 1'b1;
      #1;
      check_st("t5_async_rst", S_IDLE, 1'b0);
      #1 rst = 1'b0;
      cycle();
      check_st("t5_rearm", S_ARMED, 1'b0);
      one_tick();
      check_st("t5_no_ring", S_ARMED, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
